// File: rtl/disp_write_arb.sv
// disp_write_arb
//
// Shares the single display-RAM write port between two requesters and owns a
// clear-screen sequencer that fills cells 0..CLEAR_WORDS-1 with CLEAR_DATA.
//
// Ports:
//   clk, reset_ni          - rising-edge clock, asynchronous active-low reset
//   clear_i                - one-cycle pulse starting a clear (ignored while clearing)
//   clear_busy_o           - high while a clear is in progress
//   reqN_valid_i           - requester N has a write pending
//   reqN_ready_o           - combinational accept for requester N this cycle
//   reqN_addr_i/data_i     - requester N write address / cell word
//   wr_en_o/addr_o/data_o  - registered display-RAM write port
module disp_write_arb #(
    parameter int          ADDR_W      = 12,
    parameter int          CLEAR_WORDS = 2400,
    parameter logic [15:0] CLEAR_DATA  = 16'h0F20
) (
    input  logic              clk,
    input  logic              reset_ni,
    input  logic              clear_i,
    output logic              clear_busy_o,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [15:0]       req0_data_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [15:0]       req1_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [15:0]       wr_data_o
);

    localparam int CNT_W = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CLEAR_WORDS - 1);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;
    logic             last_grant;

    // State register
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a clear pulse in ARB always wins; the clear runs until
    // the final cell index has been issued and cannot be restarted mid-way.
    always_comb begin
        next_state = state;
        if (state == ARB) begin
            if (clear_i) begin
                next_state = CLEAR;
            end
        end else begin
            if (counter == LAST_IDX) begin
                next_state = ARB;
            end
        end
    end

    // Ready generation: round-robin on contention, last_grant names the
    // requester served most recently, so the other one wins the next tie.
    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (state == ARB && !clear_i) begin
            if (req0_valid_i && (!req1_valid_i || last_grant)) begin
                req0_ready_o = 1'b1;
            end else if (req1_valid_i) begin
                req1_ready_o = 1'b1;
            end
        end
    end

    // Registered write port, clear counter, busy flag and round-robin memory.
    // The write strobe defaults low every cycle while address and data hold.
    // The counter stops on the last index instead of wrapping.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            clear_busy_o <= 1'b0;
            counter      <= '0;
            last_grant   <= 1'b1;
        end else begin
            wr_en_o <= 1'b0;
            if (state == ARB) begin
                if (clear_i) begin
                    counter      <= '0;
                    clear_busy_o <= 1'b1;
                end else if (req0_ready_o) begin
                    wr_en_o    <= 1'b1;
                    wr_addr_o  <= req0_addr_i;
                    wr_data_o  <= req0_data_i;
                    last_grant <= 1'b0;
                end else if (req1_ready_o) begin
                    wr_en_o    <= 1'b1;
                    wr_addr_o  <= req1_addr_i;
                    wr_data_o  <= req1_data_i;
                    last_grant <= 1'b1;
                end
            end else begin
                wr_en_o   <= 1'b1;
                wr_addr_o <= ADDR_W'(counter);
                wr_data_o <= CLEAR_DATA;
                if (counter == LAST_IDX) begin
                    clear_busy_o <= 1'b0;
                end else begin
                    counter <= counter + 1'b1;
                end
            end
        end
    end

endmodule
